fb_divider: RTL and testbench

Programmable integer feedback divider for the CDR/PLL loop. It divides the VCO clock by a runtime-selectable ratio N and drives `finalclk` into the PFD, closing the loop through charge pump, loop filter and VCO. Ratio changes use a single-outstanding request handshake. A new ratio takes effect only at a period boundary, so the PFD never sees a truncated or stretched feedback edge.

---
 rtl/fb_divider_if.sv | 30 +++
 rtl/fb_divider.sv | 100 ++++++++++
 tb/tb_fb_divider.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fb_divider_if.sv
// Ratio-change request channel of the feedback divider.
// The master supplies a requested ratio and a one-cycle load strobe.
// The slave (fb_divider) reports the pending flag, the reject pulse and the ratio in use.
interface fb_divider_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             div_busy;
  logic             div_err;
  logic [WIDTH-1:0] div_active;

  modport master (
    output div_in,
    output div_load,
    input  div_busy,
    input  div_err,
    input  div_active
  );

  modport slave (
    input  div_in,
    input  div_load,
    output div_busy,
    output div_err,
    output div_active
  );

endinterface

// File: rtl/fb_divider.sv
// Programmable integer feedback divider for the PLL/CDR loop.
// The VCO clock is divided by the active ratio N to produce finalclk, which feeds the PFD.
// A new ratio is held in a shadow register and only becomes active at a period
// boundary, or on a disabled edge. This keeps every feedback period whole.
// All outputs are registered, so no input reaches an output combinationally.
module fb_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         vcoclk,
  input  logic         rst_n,
  input  logic         enable,
  fb_divider_if.slave  cfg,
  output logic         finalclk,
  output logic         tc
);

  // Phase counter, active ratio, shadow ratio and pending flag.
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] s_reg;
  logic             busy_reg;
  logic             err_reg;
  logic             finalclk_reg;
  logic             tc_reg;

  // Derived per-cycle conditions.
  logic             wrap;
  logic [WIDTH:0]   half;
  logic             high_phase;
  logic             ratio_ok;
  logic             load_accept;
  logic             load_reject;
  logic             apply_shadow;

  // The last phase of the period. N is always >= 2, so N-1 cannot underflow.
  assign wrap = (p_reg == (n_reg - WIDTH'(1)));

  // The high time is ceil(N/2). It is computed one bit wider so that N = 2^WIDTH-1 cannot overflow.
  assign half       = ({1'b0, n_reg} + (WIDTH+1)'(1)) >> 1;
  assign high_phase = ({1'b0, p_reg} < half);

  // Ratios 0 and 1 cannot form a period. Every other WIDTH-bit value is legal.
  assign ratio_ok = (cfg.div_in >= WIDTH'(2));

  // A request seen while one is already pending is dropped without an error.
  assign load_accept = cfg.div_load && !busy_reg && ratio_ok;
  assign load_reject = cfg.div_load && !busy_reg && !ratio_ok;

  // A pending ratio lands on the wrap edge, or on any disabled edge.
  // Acceptance needs busy low and apply needs busy high, so the two never collide.
  assign apply_shadow = busy_reg && (!enable || wrap);

  // Phase counter and registered waveform outputs.
  always_ff @(posedge vcoclk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg        <= '0;
      finalclk_reg <= 1'b0;
      tc_reg       <= 1'b0;
    end else if (enable) begin
      finalclk_reg <= high_phase;
      tc_reg       <= wrap;
      if (wrap) begin
        p_reg <= '0;
      end else begin
        p_reg <= p_reg + WIDTH'(1);
      end
    end else begin
      p_reg        <= '0;
      finalclk_reg <= 1'b0;
      tc_reg       <= 1'b0;
    end
  end

  // Ratio handshake: capture into the shadow register, apply at the boundary, and flag rejects.
  always_ff @(posedge vcoclk or negedge rst_n) begin
    if (!rst_n) begin
      n_reg    <= WIDTH'(DEFAULT_DIV);
      s_reg    <= '0;
      busy_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      err_reg <= load_reject;
      if (apply_shadow) begin
        n_reg    <= s_reg;
        busy_reg <= 1'b0;
      end else if (load_accept) begin
        s_reg    <= cfg.div_in;
        busy_reg <= 1'b1;
      end
    end
  end

  assign finalclk       = finalclk_reg;
  assign tc             = tc_reg;
  assign cfg.div_busy   = busy_reg;
  assign cfg.div_err    = err_reg;
  assign cfg.div_active = n_reg;

endmodule

// File: tb/tb_fb_divider.sv
// Self-checking bench for fb_divider.
// A behavioural model tracks the position within the current period and the ratio
// bookkeeping using integer arithmetic. A compare process checks every output on
// every falling edge. A directed sequence pins the model with literal expectations,
// and a randomized phase then stresses it.
module tb_fb_divider;

  localparam int W = 8;

  logic vcoclk = 1'b0;
  logic rst_n  = 1'b1;
  logic enable = 1'b0;
  logic finalclk;
  logic tc;
  bit   check_en = 1'b0;

  int total = 0;
  int bad   = 0;

  fb_divider_if #(.WIDTH(W)) bus ();

  fb_divider #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .vcoclk   (vcoclk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cfg      (bus),
    .finalclk (finalclk),
    .tc       (tc)
  );

  always #5 vcoclk = ~vcoclk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: position within the period, ratio bookkeeping, and expected outputs.
  int m_pos  = 0;
  int m_n    = 4;
  int m_s    = 0;
  bit m_pend = 0;
  bit m_fc   = 0;
  bit m_tc   = 0;
  bit m_err  = 0;

  always @(posedge vcoclk or negedge rst_n) begin
    bit was_pending;
    if (!rst_n) begin
      m_pos = 0; m_n = 4; m_s = 0; m_pend = 0; m_fc = 0; m_tc = 0; m_err = 0;
    end else begin
      was_pending = m_pend;
      if (enable) begin
        m_fc = (m_pos < (m_n + 1) / 2);
        m_tc = (m_pos == m_n - 1);
        if (m_tc) begin
          m_pos = 0;
          if (was_pending) begin m_n = m_s; m_pend = 0; end
        end else begin
          m_pos = m_pos + 1;
        end
      end else begin
        m_pos = 0; m_fc = 0; m_tc = 0;
        if (was_pending) begin m_n = m_s; m_pend = 0; end
      end
      m_err = 0;
      if (bus.div_load && !was_pending) begin
        if (int'(bus.div_in) < 2) m_err = 1;
        else begin m_s = int'(bus.div_in); m_pend = 1; end
      end
    end
  end

  // Compare every output with the model on each falling edge.
  always @(negedge vcoclk) begin
    if (check_en) begin
      chk("finalclk", int'(finalclk), int'(m_fc));
      chk("tc", int'(tc), int'(m_tc));
      chk("div_busy", int'(bus.div_busy), int'(m_pend));
      chk("div_err", int'(bus.div_err), int'(m_err));
      chk("div_active", int'(bus.div_active), m_n);
    end
  end

  task automatic step();
    @(negedge vcoclk);
    #1;
  endtask

  task automatic load(input int val);
    bus.div_load = 1'b1;
    bus.div_in   = W'(val);
    step();
    bus.div_load = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (bus.div_busy && n < max_cycles) begin
      step();
      n++;
    end
    chk("busy_timeout", int'(bus.div_busy), 0);
  endtask

  initial begin
    int highs;
    int guard;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    enable       = 1'b1;
    #1 rst_n = 1'b0;
    check_en = 1'b1;
    #2;
    // Reset values while enable is held high.
    repeat (3) step();
    chk("rst_finalclk", int'(finalclk), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_busy", int'(bus.div_busy), 0);
    chk("rst_err", int'(bus.div_err), 0);
    chk("rst_active", int'(bus.div_active), 4);
    rst_n = 1'b1;
    // Default ratio: finalclk runs 1,1,0,0 and tc is high with the second 0.
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("n4_finalclk", int'(finalclk), (((k - 1) % 4) < 2) ? 1 : 0);
      chk("n4_tc", int'(tc), ((k % 4) == 0) ? 1 : 0);
    end

    // Odd ratio 5: 3 cycles high, then 2 cycles low.
    load(5);
    chk("odd_busy", int'(bus.div_busy), 1);
    chk("odd_active_old", int'(bus.div_active), 4);
    wait_idle(10);
    chk("odd_active", int'(bus.div_active), 5);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("odd_finalclk", int'(finalclk), (k <= 3) ? 1 : 0);
    end
    chk("odd_tc", int'(tc), 1);

    // Mid-period change: with N=4, load 6 at p=1. A second request (7) while busy is ignored.
    load(4);
    wait_idle(10);
    step();
    load(6);
    chk("mid_busy", int'(bus.div_busy), 1);
    load(7);
    chk("mid_active_old", int'(bus.div_active), 4);
    step();
    chk("mid_busy_clear", int'(bus.div_busy), 0);
    chk("mid_active", int'(bus.div_active), 6);
    highs = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      highs += int'(finalclk);
    end
    chk("mid_highs", highs, 3);
    chk("mid_tc", int'(tc), 1);
    repeat (6) step();
    chk("mid_final_ratio", int'(bus.div_active), 6);

    // Invalid ratios 1 and 0 each give a one-cycle error and change nothing.
    load(1);
    chk("inv1_err", int'(bus.div_err), 1);
    chk("inv1_busy", int'(bus.div_busy), 0);
    chk("inv1_active", int'(bus.div_active), 6);
    load(0);
    chk("inv0_err", int'(bus.div_err), 1);
    step();
    chk("inv_err_clear", int'(bus.div_err), 0);
    chk("inv_active", int'(bus.div_active), 6);

    // Enable gating: drop enable at p=2 of N=8 while ratio 3 is pending.
    load(8);
    wait_idle(10);
    load(3);
    chk("gate_busy", int'(bus.div_busy), 1);
    step();
    enable = 1'b0;
    step();
    chk("gate_finalclk", int'(finalclk), 0);
    chk("gate_active", int'(bus.div_active), 3);
    chk("gate_busy_clear", int'(bus.div_busy), 0);
    step();
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("reen_finalclk", int'(finalclk), (k <= 2) ? 1 : 0);
    end

    // Asynchronous reset in the middle of a cycle, with finalclk high and a load pending.
    load(20);
    chk("ar_busy", int'(bus.div_busy), 1);
    guard = 0;
    while (!finalclk && guard < 40) begin
      step();
      guard++;
    end
    chk("ar_fc_high", int'(finalclk), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_fc_drop", int'(finalclk), 0);
    chk("ar_busy_drop", int'(bus.div_busy), 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("ar_active", int'(bus.div_active), 4);
    chk("ar_busy_after", int'(bus.div_busy), 0);

    // Randomized traffic, checked each cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      enable       = ($urandom_range(0, 15) != 0);
      bus.div_load = ($urandom_range(0, 4) == 0);
      bus.div_in   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                 : W'($urandom_range(0, 9));
      if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end
    bus.div_load = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
